// File: rtl/freq_meter_gated.sv
// Gated-window frequency meter: counts edges of an async input over GATE_CYCLES clocks,
// converts each window's count to BCD and drives a time-multiplexed 7-segment display.
module freq_meter_gated #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 14,
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sig,
  input  logic                  edge_mode,
  input  logic                  hold,
  output logic [CNT_W-1:0]      count_o,
  output logic                  result_valid,
  output logic                  overflow,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] dig_sel
);

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int GATE_W  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int BCD_MIN = (CNT_W + 2) / 3;
  localparam int BCD_N   = (BCD_MIN > NUM_DIGITS) ? BCD_MIN : NUM_DIGITS;
  localparam int SH_W    = 4 * BCD_N + CNT_W;
  localparam int BIT_W   = $clog2(CNT_W + 1);
  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [31:0]      MAX_DEC = 32'(pow10(NUM_DIGITS) - 1);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // One double-dabble iteration: correct every BCD nibble, then shift the whole register left.
  function automatic logic [SH_W-1:0] dabble(input logic [SH_W-1:0] v);
    logic [SH_W-1:0] t;
    t = v;
    for (int i = 0; i < BCD_N; i++) begin
      if (t[CNT_W + 4*i +: 4] >= 4'd5) t[CNT_W + 4*i +: 4] = t[CNT_W + 4*i +: 4] + 4'd3;
    end
    return t << 1;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic                    sync1_q, sync1_d, sync2_q, sync2_d, dly_q, dly_d;
  logic [GATE_W-1:0]       gate_q, gate_d;
  logic [CNT_W-1:0]        ecnt_q, ecnt_d, ecnt_inc;
  logic                    sat_q, sat_d, snap_sat_q, snap_sat_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [SH_W-1:0]         sh_q, sh_d;
  logic                    result_valid_q, result_valid_d;
  logic                    overflow_q, overflow_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [SCAN_W-1:0]       scan_q, scan_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_sel_q, dig_sel_d;
  logic                    edge_det, snap, sat_hit, win_sat, range_ovf;
  logic                    do_load, do_shift, do_done;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    higher_nz;
  logic [3:0]              cur_digit;

  always_comb begin
    sync1_d  = sig;
    sync2_d  = sync1_q;
    dly_d    = sync2_q;
    edge_det = edge_mode ? (sync2_q ^ dly_q) : (sync2_q & ~dly_q);
    snap     = (gate_q == GATE_W'(GATE_CYCLES - 1));
    gate_d   = snap ? '0 : gate_q + 1'b1;
    // An edge arriving at full scale is lost; remember that the window under-counted.
    sat_hit    = edge_det & (ecnt_q == CNT_MAX);
    ecnt_inc   = (edge_det & ~sat_hit) ? ecnt_q + 1'b1 : ecnt_q;
    win_sat    = sat_q | sat_hit;
    ecnt_d     = snap ? '0 : ecnt_inc;
    sat_d      = snap ? 1'b0 : win_sat;
    count_d    = snap ? ecnt_inc : count_q;
    snap_sat_d = snap ? win_sat : snap_sat_q;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (snap) state_d = S_SHIFT;
      S_SHIFT: if (bit_q == BIT_W'(CNT_W - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    do_load  = (state_q == S_IDLE) & snap;
    do_shift = (state_q == S_SHIFT);
    do_done  = (state_q == S_DONE);
  end

  always_comb begin
    bit_d = do_shift ? bit_q + 1'b1 : '0;
    sh_d  = sh_q;
    if (do_load)       sh_d = {{(4*BCD_N){1'b0}}, ecnt_inc};
    else if (do_shift) sh_d = dabble(sh_q);
    // Range check uses the full binary count, before surplus BCD digits are dropped.
    range_ovf      = snap_sat_q | (32'(count_q) > MAX_DEC);
    result_valid_d = do_done;
    overflow_d     = do_done ? range_ovf : overflow_q;
    digits_d       = digits_q;
    if (do_done && !hold) begin
      digits_d = range_ovf ? {NUM_DIGITS{4'h9}} : sh_q[CNT_W +: 4*NUM_DIGITS];
    end
  end

  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    // Blank a digit when it and everything above it is zero; the units digit always shows.
    blank     = '0;
    higher_nz = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      higher_nz = higher_nz | (digits_q[4*i +: 4] != 4'd0);
      blank[i]  = (i != 0) && !higher_nz;
    end
    cur_digit = digits_q[{idx_q, 2'b00} +: 4];
    seg_d     = blank[idx_q] ? 7'h00 : seg7(cur_digit);
    dig_sel_d = NUM_DIGITS'(1) << idx_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      dly_q          <= 1'b0;
      gate_q         <= '0;
      ecnt_q         <= '0;
      sat_q          <= 1'b0;
      snap_sat_q     <= 1'b0;
      count_q        <= '0;
      bit_q          <= '0;
      sh_q           <= '0;
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      digits_q       <= '0;
      scan_q         <= '0;
      idx_q          <= '0;
      seg_q          <= 7'h3F;
      dig_sel_q      <= NUM_DIGITS'(1);
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      dly_q          <= dly_d;
      gate_q         <= gate_d;
      ecnt_q         <= ecnt_d;
      sat_q          <= sat_d;
      snap_sat_q     <= snap_sat_d;
      count_q        <= count_d;
      bit_q          <= bit_d;
      sh_q           <= sh_d;
      result_valid_q <= result_valid_d;
      overflow_q     <= overflow_d;
      digits_q       <= digits_d;
      scan_q         <= scan_d;
      idx_q          <= idx_d;
      seg_q          <= seg_d;
      dig_sel_q      <= dig_sel_d;
    end
  end

  assign count_o      = count_q;
  assign result_valid = result_valid_q;
  assign overflow     = overflow_q;
  assign seg          = seg_q;
  assign dig_sel      = dig_sel_q;

endmodule

// File: tb/tb_freq_meter_gated.sv
// Directed bench for freq_meter_gated: a 3-digit and a 2-digit instance share clock, reset and sig;
// windows of 100 clk, 10-bit counter, 4 clk per scanned digit.
module tb_freq_meter_gated;

  logic       clk, reset, sig, edge_mode, hold;
  logic [9:0] count_o, count2;
  logic       rv, rv2, ovf, ovf2;
  logic [6:0] seg, seg2;
  logic [2:0] dig_sel;
  logic [1:0] dig_sel2;
  int         n_chk = 0;
  int         n_err = 0;
  int         half = 5;
  int         n;

  freq_meter_gated #(.GATE_CYCLES(100), .CNT_W(10), .NUM_DIGITS(3), .SCAN_DIV(4)) dut (
    .clk(clk), .reset(reset), .sig(sig), .edge_mode(edge_mode), .hold(hold),
    .count_o(count_o), .result_valid(rv), .overflow(ovf), .seg(seg), .dig_sel(dig_sel));

  freq_meter_gated #(.GATE_CYCLES(100), .CNT_W(10), .NUM_DIGITS(2), .SCAN_DIV(4)) dut2 (
    .clk(clk), .reset(reset), .sig(sig), .edge_mode(edge_mode), .hold(hold),
    .count_o(count2), .result_valid(rv2), .overflow(ovf2), .seg(seg2), .dig_sel(dig_sel2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // sig toggles every 'half' clocks, off-edge so it looks asynchronous to the sampler.
  initial begin
    int ph;
    ph  = 0;
    sig = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      ph++;
      if (ph >= half) begin
        ph  = 0;
        sig = ~sig;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_res(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (!rv && cnt < 300);
    if (!rv) chk("rv_timeout", 0, 1);
  endtask

  task automatic scan_chk(input string tag, input int which, input int nd,
                          input int e0, input int e1, input int e2);
    int ds[20];
    int sg[20];
    int k, p0, p, es;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      ds[i] = which ? int'(dig_sel2) : int'(dig_sel);
      sg[i] = which ? int'(seg2) : int'(seg);
    end
    k = 0;
    for (int i = 1; i < 20; i++) if (k == 0 && ds[i] != ds[i-1]) k = i;
    if (k == 0 || k > 8) begin
      chk({tag, "_adv"}, 0, 1);
      k = 1;
    end
    p0 = 0;
    for (int b = 0; b < nd; b++) if (ds[k] == (1 << b)) p0 = b;
    chk({tag, "_prev"}, ds[k-1], 1 << ((p0 + nd - 1) % nd));
    for (int j = 0; j < 12; j++) begin
      p  = (p0 + j / 4) % nd;
      es = (p == 0) ? e0 : ((p == 1) ? e1 : e2);
      chk({tag, "_sel"}, ds[k+j], 1 << p);
      chk({tag, "_seg"}, sg[k+j], es);
    end
  endtask

  initial begin
    reset     = 1'b1;
    edge_mode = 1'b0;
    hold      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", count_o, 0);
    chk("rst_rv", rv, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_dig_sel", dig_sel, 1);
    chk("rst_seg", seg, 7'h3F);
    chk("rst_count2", count2, 0);
    chk("rst_dig_sel2", dig_sel2, 1);
    reset = 1'b0;

    // Period 10, rising edges: cycles counted from the one in which reset drops.
    wait_res(n);
    chk("first_latency", n + 1, 112);
    wait_res(n);
    chk("window_period", n, 100);
    chk("rise_count", count_o, 10);
    chk("rise_ovf", ovf, 0);
    @(posedge clk);
    #1;
    chk("rv_one_cycle", rv, 0);
    wait_res(n);
    chk("rise_count_w3", count_o, 10);
    scan_chk("scan10", 0, 3, 7'h3F, 7'h06, 7'h00);

    // Both edges.
    edge_mode = 1'b1;
    wait_res(n);
    wait_res(n);
    chk("both_count", count_o, 20);
    chk("both_ovf", ovf, 0);
    scan_chk("scan20", 0, 3, 7'h3F, 7'h5B, 7'h00);

    // Toggle every clk: 100 edges overflows the 2-digit instance only.
    half = 1;
    wait_res(n);
    wait_res(n);
    chk("fast_count", count_o, 100);
    chk("fast_ovf", ovf, 0);
    chk("fast_rv2", rv2, 1);
    chk("fast_count2", count2, 100);
    chk("fast_ovf2", ovf2, 1);
    scan_chk("scan100", 0, 3, 7'h3F, 7'h3F, 7'h06);
    scan_chk("scan99", 1, 2, 7'h6F, 7'h6F, 0);

    half      = 5;
    edge_mode = 1'b0;
    wait_res(n);
    wait_res(n);
    chk("slow_count2", count2, 10);
    chk("slow_ovf2", ovf2, 0);
    scan_chk("scan10_2", 1, 2, 7'h3F, 7'h06, 0);

    // Hold keeps "10" on the display while the measurement moves to 25.
    hold = 1'b1;
    half = 2;
    wait_res(n);
    wait_res(n);
    chk("hold_rv", rv, 1);
    chk("hold_count", count_o, 25);
    chk("hold_ovf", ovf, 0);
    scan_chk("scan_hold", 0, 3, 7'h3F, 7'h06, 7'h00);
    hold = 1'b0;
    wait_res(n);
    chk("unhold_count", count_o, 25);
    scan_chk("scan25", 0, 3, 7'h6D, 7'h5B, 7'h00);

    // A result is visible 12 cycles after the gate=99 snapshot, so gate is 11 now.
    wait_res(n);
    repeat (39) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_count", count_o, 0);
    chk("mid_rst_rv", rv, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_dig_sel", dig_sel, 1);
    chk("mid_rst_seg", seg, 7'h3F);
    reset = 1'b0;
    wait_res(n);
    chk("mid_rst_latency", n + 1, 112);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
